// File: rtl/jtframe_sdram_arb.sv
// jtframe_sdram_arb: grants SLOTS client ports, one access per chip-select assertion, onto a
// single SDRAM controller request port. Define JTFRAME_SDRAM_RR_EN for round-robin grants.
module jtframe_sdram_arb #(
    parameter int               SLOTS   = 4,
    parameter logic [SLOTS-1:0] WRSLOTS = {SLOTS{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic                vblank,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS-1:0]    slot_wr,
    input  logic [SLOTS*22-1:0] slot_addr,
    input  logic [SLOTS*16-1:0] slot_din,
    input  logic [SLOTS*2-1:0]  slot_wrmask,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [31:0]         slot_dout,
    output logic [SLOTS-1:0]    slot_active,
    output logic                sdram_req,
    input  logic                sdram_ack,
    output logic                sdram_rnw,
    output logic [21:0]         sdram_addr,
    output logic [1:0]          sdram_wrmask,
    output logic [15:0]         data_write,
    input  logic                data_rdy,
    input  logic [31:0]         data_read,
    output logic                refresh_en
);

    localparam int               IW   = $clog2(SLOTS);
    localparam logic [SLOTS-1:0] NONE = {SLOTS{1'b0}};
    localparam logic [SLOTS-1:0] ONE  = {{(SLOTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t           state_r;
    logic [SLOTS-1:0] served_r;
    logic [SLOTS-1:0] pending_s;
    logic [SLOTS-1:0] done_s;
    logic             grant_vld_s;
    logic [IW-1:0]    grant_idx_s;
    logic             wr_ok_s;
    logic [21:0]      addr_s [SLOTS];
    logic [15:0]      din_s  [SLOTS];
    logic [1:0]       mask_s [SLOTS];

`ifdef JTFRAME_SDRAM_RR_EN
    logic [IW-1:0]    rr_ptr_r;
    logic [IW-1:0]    rr_next_s;
    logic [IW-1:0]    rr_sel_s;
    int               rr_idx_s;
`endif

    assign pending_s = slot_cs & ~served_r;

    // Unflatten the client buses so the granted slot can be selected by index
    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            addr_s[i] = slot_addr[22*i +: 22];
            din_s[i]  = slot_din[16*i +: 16];
            mask_s[i] = slot_wrmask[2*i +: 2];
        end
    end

    // Grant selection; scanning downwards leaves the first match of the search order
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = {IW{1'b0}};
`ifdef JTFRAME_SDRAM_RR_EN
        rr_idx_s = 0;
        rr_sel_s = {IW{1'b0}};
        for (int k = SLOTS-1; k >= 0; k--) begin
            rr_idx_s = int'(rr_ptr_r) + k;
            if (rr_idx_s >= SLOTS) begin
                rr_idx_s = rr_idx_s - SLOTS;
            end else begin
                rr_idx_s = rr_idx_s;
            end
            rr_sel_s = IW'(rr_idx_s);
            if (pending_s[rr_sel_s]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = rr_sel_s;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
`else
        for (int i = SLOTS-1; i >= 0; i--) begin
            if (pending_s[i]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = IW'(i);
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
`endif
    end

    // Write permission of the candidate slot and completion mask of the current access
    always_comb begin
        wr_ok_s = slot_wr[grant_idx_s] & WRSLOTS[grant_idx_s];
        if (state_r == ST_WAIT && data_rdy) begin
            done_s = slot_active;
        end else begin
            done_s = NONE;
        end
    end

    // Request/acknowledge/data-ready sequencer with all controller-side outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            sdram_req    <= 1'b0;
            sdram_rnw    <= 1'b1;
            sdram_addr   <= 22'd0;
            sdram_wrmask <= 2'b11;
            data_write   <= 16'd0;
            slot_active  <= NONE;
            slot_ok      <= NONE;
            slot_dout    <= 32'd0;
            refresh_en   <= 1'b0;
        end else if (downloading) begin
            state_r     <= ST_IDLE;
            sdram_req   <= 1'b0;
            slot_active <= NONE;
            slot_ok     <= NONE;
            refresh_en  <= 1'b0;
        end else begin
            slot_ok    <= NONE;
            refresh_en <= (state_r == ST_IDLE) && (pending_s == NONE) && vblank;
            case (state_r)
                ST_IDLE: begin
                    if (grant_vld_s) begin
                        slot_active  <= ONE << grant_idx_s;
                        sdram_addr   <= addr_s[grant_idx_s];
                        data_write   <= din_s[grant_idx_s];
                        sdram_rnw    <= ~wr_ok_s;
                        sdram_wrmask <= wr_ok_s ? mask_s[grant_idx_s] : 2'b11;
                        sdram_req    <= 1'b1;
                        state_r      <= ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // data_rdy is not looked at here, even if it coincides with the ack
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        state_r   <= ST_WAIT;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (data_rdy) begin
                        slot_dout   <= data_read;
                        slot_ok     <= slot_active;
                        slot_active <= NONE;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    sdram_req   <= 1'b0;
                    slot_active <= NONE;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // A slot stays served from its completion until it drops chip select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            served_r <= NONE;
        end else if (downloading) begin
            served_r <= NONE;
        end else begin
            served_r <= (served_r | done_s) & slot_cs;
        end
    end

`ifdef JTFRAME_SDRAM_RR_EN
    assign rr_next_s = (grant_idx_s == IW'(SLOTS-1)) ? {IW{1'b0}} : grant_idx_s + IW'(1);

    // Round-robin pointer holds the slot where the next search begins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= {IW{1'b0}};
        end else if (!downloading && state_r == ST_IDLE && grant_vld_s) begin
            rr_ptr_r <= rr_next_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

endmodule
